seatbelt_alarm: RTL and testbench

Parametrised multi-seat seat-belt warning controller, the successor to the single-seat combinational warning with its fixed 5-second trigger. It monitors N seats against the ignition key and waits a programmable grace period before raising the warning. It sounds the warning for a bounded time, then mutes, and re-arms when a new seat goes unbelted. It sits between the cabin sensor inputs and the dashboard warning driver.

---
 rtl/seatbelt_pkg.sv | 16 +
 rtl/tick_prescaler.sv | 36 +++
 rtl/seatbelt_alarm.sv | 134 +++++++++++++
 tb/tb_seatbelt_alarm.sv | 135 +++++++++++++
 4 files changed

// File: rtl/seatbelt_pkg.sv
// Shared types and constants for the multi-seat seat-belt warning controller.
//   sb_state_t : controller FSM state encoding
//   SEC_W      : width of the whole-seconds counter
package seatbelt_pkg;

  localparam int unsigned SEC_W = 8;

  typedef enum logic [2:0] {
    StIdle  = 3'd0,
    StArmed = 3'd1,
    StWait  = 3'd2,
    StAlarm = 3'd3,
    StMute  = 3'd4
  } sb_state_t;

endpackage

// File: rtl/tick_prescaler.sv
// Divides the clock down to a one-cycle tick every DIV cycles.
//   clk_i  : clock
//   rst_i  : synchronous active-high reset
//   clr_i  : restart the count from 0 (takes effect on the next edge)
//   tick_o : high for the single cycle in which the count sits at DIV-1
module tick_prescaler #(
  parameter int unsigned DIV = 50_000_000
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clr_i,
  output logic tick_o
);

  localparam int unsigned W = $clog2(DIV);
  localparam logic [W-1:0] Last = W'(DIV - 1);

  logic [W-1:0] div_q, div_d;

  always_comb begin
    tick_o = (div_q == Last);
    div_d  = div_q + 1'b1;
    if (clr_i || tick_o) begin
      div_d = '0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      div_q <= '0;
    end else begin
      div_q <= div_d;
    end
  end

endmodule

// File: rtl/seatbelt_alarm.sv
// Multi-seat seat-belt warning controller. Waits WAIT_S seconds after any
// occupied seat is unbelted with the key on, sounds the warning for ALARM_S
// seconds, then mutes until a further seat becomes unbelted.
//   clk_i  : clock
//   rst_i  : synchronous active-high reset
//   k_i    : ignition key on
//   p_i    : seat occupied, one bit per seat
//   b_i    : belt fastened, one bit per seat
//   w_o    : warning output (blinks per tick when BLINK is set)
//   seat_o : registered per-seat violation mask
//   mute_o : high while the warning is muted
module seatbelt_alarm
  import seatbelt_pkg::*;
#(
  parameter int unsigned N_SEATS  = 4,
  parameter int unsigned TICK_DIV = 50_000_000,
  parameter int unsigned WAIT_S   = 5,
  parameter int unsigned ALARM_S  = 30,
  parameter int unsigned BLINK    = 1
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               k_i,
  input  logic [N_SEATS-1:0] p_i,
  input  logic [N_SEATS-1:0] b_i,
  output logic               w_o,
  output logic [N_SEATS-1:0] seat_o,
  output logic               mute_o
);

  localparam logic [SEC_W-1:0] WaitLast  = SEC_W'(WAIT_S - 1);
  localparam logic [SEC_W-1:0] AlarmLast = SEC_W'(ALARM_S - 1);

  sb_state_t          state_q, state_d;
  logic [SEC_W-1:0]   sec_q, sec_d;
  logic               ph_q, ph_d;
  logic [N_SEATS-1:0] seat_q;

  logic [N_SEATS-1:0] v;
  logic               any_v, new_v;
  logic               tick, restart, clr;

  assign v     = p_i & ~b_i & {N_SEATS{k_i}};
  assign any_v = |v;
  assign new_v = |(v & ~seat_q);

  tick_prescaler #(
    .DIV (TICK_DIV)
  ) u_prescaler (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .clr_i  (clr),
    .tick_o (tick)
  );

  // Priority: key off, no violation, timeout, new violating seat.
  always_comb begin
    state_d = state_q;
    restart = 1'b0;
    if (!k_i) begin
      state_d = StIdle;
    end else begin
      unique case (state_q)
        StIdle:  state_d = StArmed;
        StArmed: if (any_v) state_d = StWait;
        StWait: begin
          if (!any_v) begin
            state_d = StArmed;
          end else if (tick && (sec_q == WaitLast)) begin
            state_d = StAlarm;
          end
        end
        StAlarm: begin
          if (!any_v) begin
            state_d = StArmed;
          end else if (tick && (sec_q == AlarmLast)) begin
            state_d = StMute;
          end else if (new_v) begin
            restart = 1'b1;
          end
        end
        StMute: begin
          if (!any_v) begin
            state_d = StArmed;
          end else if (new_v) begin
            state_d = StAlarm;
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  // Every timed state counts whole seconds from its own entry.
  assign clr = (state_d != state_q) || restart;

  always_comb begin
    sec_d = sec_q;
    if (clr) begin
      sec_d = '0;
    end else if (tick) begin
      sec_d = sec_q + 1'b1;
    end
  end

  // Blink phase starts high on every (re)start of the alarm.
  always_comb begin
    ph_d = ph_q;
    if ((state_d == StAlarm && state_q != StAlarm) || restart) begin
      ph_d = 1'b1;
    end else if (state_q == StAlarm && tick) begin
      ph_d = ~ph_q;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= StIdle;
      sec_q   <= '0;
      ph_q    <= 1'b0;
      seat_q  <= '0;
    end else begin
      state_q <= state_d;
      sec_q   <= sec_d;
      ph_q    <= ph_d;
      seat_q  <= v;
    end
  end

  assign w_o    = (state_q == StAlarm) && ((BLINK != 0) ? ph_q : 1'b1);
  assign mute_o = (state_q == StMute);
  assign seat_o = seat_q;

endmodule

// File: tb/tb_seatbelt_alarm.sv
module tb_seatbelt_alarm;
  import seatbelt_pkg::*;

  logic       clk = 1'b0;
  logic       rst, k;
  logic [3:0] p, b;
  logic       w, w_b, mute, mute_b;
  logic [3:0] seat, seat_b;

  int tests = 0;
  int fails = 0;

  typedef struct {
    logic       w;
    logic       wb;
    logic       m;
    logic [3:0] s;
    sb_state_t  st;
    string      tag;
  } exp_t;

  exp_t sb_q[$];

  always #5 clk = ~clk;

  seatbelt_alarm #(
    .N_SEATS(4), .TICK_DIV(10), .WAIT_S(3), .ALARM_S(5), .BLINK(0)
  ) dut (
    .clk_i(clk), .rst_i(rst), .k_i(k), .p_i(p), .b_i(b),
    .w_o(w), .seat_o(seat), .mute_o(mute)
  );

  seatbelt_alarm #(
    .N_SEATS(4), .TICK_DIV(10), .WAIT_S(3), .ALARM_S(5), .BLINK(1)
  ) dut_b (
    .clk_i(clk), .rst_i(rst), .k_i(k), .p_i(p), .b_i(b),
    .w_o(w_b), .seat_o(seat_b), .mute_o(mute_b)
  );

  task automatic cmp(input string tag, input string what, input logic [7:0] got,
                     input logic [7:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s %s: got %0h expected %0h", tag, what, got, exp);
    end
  endtask

  // Push the expectation for the next edge, advance, then pop and compare.
  task automatic cyc(input logic ew, input logic ewb, input logic em, input logic [3:0] es,
                     input sb_state_t est, input string tag);
    exp_t e;
    e = '{w: ew, wb: ewb, m: em, s: es, st: est, tag: tag};
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    e = sb_q.pop_front();
    cmp(e.tag, "w_o", {7'd0, w}, {7'd0, e.w});
    cmp(e.tag, "w_o(blink)", {7'd0, w_b}, {7'd0, e.wb});
    cmp(e.tag, "mute_o", {7'd0, mute}, {7'd0, e.m});
    cmp(e.tag, "seat_o", {4'd0, seat}, {4'd0, e.s});
    cmp(e.tag, "state", {5'd0, dut.state_q}, {5'd0, e.st});
  endtask

  // Alarm samples j0..j0+n-1 counted from (re)entry; blink is high for even decades.
  task automatic alarm_run(input int j0, input int n, input logic [3:0] es, input string tag);
    for (int j = j0; j < j0 + n; j++) begin
      cyc(1'b1, ((j / 10) % 2) == 0, 1'b0, es, StAlarm, tag);
    end
  endtask

  task automatic wait_run(input int n, input logic [3:0] es, input string tag);
    for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 1'b0, es, StWait, tag);
  endtask

  initial begin
    rst = 1'b1; k = 1'b1; p = 4'hF; b = 4'h0;
    #1;
    // Reset holds everything at zero even with violations present.
    for (int i = 0; i < 5; i++) cyc(1'b0, 1'b0, 1'b0, 4'h0, StIdle, "reset");
    rst = 1'b0;
    cyc(1'b0, 1'b0, 1'b0, 4'hF, StArmed, "reset_release");
    cyc(1'b0, 1'b0, 1'b0, 4'hF, StWait, "reset_to_wait");
    rst = 1'b1; k = 1'b0; p = 4'h0;
    cyc(1'b0, 1'b0, 1'b0, 4'h0, StIdle, "reset_mid_wait");
    rst = 1'b0;

    // Grace then alarm on seat 2.
    k = 1'b1; p = 4'b0100;
    cyc(1'b0, 1'b0, 1'b0, 4'b0100, StArmed, "grace_armed");
    cyc(1'b0, 1'b0, 1'b0, 4'b0100, StWait, "grace_wait_entry");
    wait_run(29, 4'b0100, "grace_wait");
    alarm_run(0, 50, 4'b0100, "grace_alarm");
    cyc(1'b0, 1'b0, 1'b1, 4'b0100, StMute, "grace_mute");
    cyc(1'b0, 1'b0, 1'b1, 4'b0100, StMute, "mute_hold");

    // New seat 0 re-enters ALARM; new seat 3 collides with the timeout.
    p = 4'b0101;
    alarm_run(0, 50, 4'b0101, "rearm_alarm");
    p = 4'b1101;
    cyc(1'b0, 1'b0, 1'b1, 4'b1101, StMute, "collision_mute");
    cyc(1'b0, 1'b0, 1'b1, 4'b1101, StMute, "collision_hold");

    // Seat 1 re-enters ALARM; belting/unbelting seat 3 restarts the count.
    p = 4'b1111;
    alarm_run(0, 6, 4'b1111, "restart_pre");
    b = 4'b1000;
    alarm_run(6, 6, 4'b0111, "restart_belted");
    b = 4'b0000;
    alarm_run(0, 3, 4'b1111, "restart_post");

    // Key off mid-alarm, then key on restarts the full grace period.
    k = 1'b0;
    cyc(1'b0, 1'b0, 1'b0, 4'h0, StIdle, "keyoff_idle");
    k = 1'b1;
    cyc(1'b0, 1'b0, 1'b0, 4'hF, StArmed, "keyon_armed");
    cyc(1'b0, 1'b0, 1'b0, 4'hF, StWait, "keyon_wait_entry");
    wait_run(29, 4'hF, "keyon_wait");
    alarm_run(0, 1, 4'hF, "keyon_alarm");

    // Belt fastened before timeout.
    k = 1'b0;
    cyc(1'b0, 1'b0, 1'b0, 4'h0, StIdle, "belt_idle");
    k = 1'b1; p = 4'b0100; b = 4'h0;
    cyc(1'b0, 1'b0, 1'b0, 4'b0100, StArmed, "belt_armed");
    cyc(1'b0, 1'b0, 1'b0, 4'b0100, StWait, "belt_wait_entry");
    wait_run(24, 4'b0100, "belt_wait");
    b = 4'b0100;
    for (int i = 0; i < 21; i++) cyc(1'b0, 1'b0, 1'b0, 4'h0, StArmed, "belt_rearmed");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
